// File: rtl/fb_init_pkg.sv
// Shared encodings for the frame-buffer init sequencer: FSM states, fill patterns, mode width.
package fb_init_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [2:0] {
        ST_HOLDOFF,
        ST_WAIT_RDY,
        ST_FILL,
        ST_SETTLE,
        ST_DONE
    } state_e;

    typedef enum logic [MODE_W-1:0] {
        PAT_SOLID,
        PAT_STRIPE,
        PAT_CHECKER,
        PAT_RAMP
    } pattern_e;

endpackage

// File: rtl/fb_pattern_gen.sv
// Test-pattern source: wrapping column/row/ramp counters that track the next fill address,
// plus the pattern mux. Config is captured on load so it stays fixed for a whole fill.
module fb_pattern_gen
    import fb_init_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 4,
    parameter int H_RES  = 640
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic [DATA_W-1:0] color0_i,
    input  logic [DATA_W-1:0] color1_i,
    input  logic [2:0]        shift_i,
    output logic [DATA_W-1:0] data_o
);

    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);

    pattern_e          mode_q;
    logic [DATA_W-1:0] color0_q, color1_q;
    logic [2:0]        shift_q;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [DATA_W-1:0] ramp_q, ramp_d;
    logic              col_bit, row_bit;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        ramp_d = ramp_q;
        if (load_i) begin
            col_d  = '0;
            row_d  = '0;
            ramp_d = '0;
        end else if (advance_i) begin
            ramp_d = ramp_q + 1'b1;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q   <= PAT_SOLID;
            color0_q <= '0;
            color1_q <= '0;
            shift_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            ramp_q   <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            ramp_q <= ramp_d;
            if (load_i) begin
                mode_q   <= pattern_e'(mode_i);
                color0_q <= color0_i;
                color1_q <= color1_i;
                shift_q  <= shift_i;
            end
        end
    end

    // Bit 'shift' of the counter is bit 0 of (counter >> shift), zero once shifted past the top.
    assign col_bit = |(col_q & (COL_W'(1) << shift_q));
    assign row_bit = |(row_q & (ADDR_W'(1) << shift_q));

    // NOTE: data_o gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        data_o = color0_q;
        case (mode_q)
            PAT_STRIPE:  data_o = col_bit ? color1_q : color0_q;
            PAT_CHECKER: data_o = (col_bit ^ row_bit) ? color1_q : color0_q;
            PAT_RAMP:    data_o = ramp_q;
            default:     data_o = color0_q;
        endcase
    end

endmodule

// File: rtl/fb_init_sequencer.sv
// Frame-buffer initialiser: holds the buffer in reset, waits for ready, fills every address with
// a test pattern, settles, then raises done. Define FB_INIT_SEQ_BACKPRESSURE_EN to add wr_ready.
module fb_init_sequencer
    import fb_init_pkg::*;
#(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 4,
    parameter int DEPTH   = 256000,
    parameter int H_RES   = 640,
    parameter int HOLDOFF = 8,
    parameter int SETTLE  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    input  logic [DATA_W-1:0] color0,
    input  logic [DATA_W-1:0] color1,
    input  logic [2:0]        shift,
    input  logic              fb_ready,
`ifdef FB_INIT_SEQ_BACKPRESSURE_EN
    input  logic              wr_ready,
`endif
    output logic              fb_rst_n,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX = (HOLDOFF > SETTLE) ? HOLDOFF : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              fb_rst_n_q, fb_rst_n_d;
    logic              busy_q, done_q;
    logic              load, issue, pending;
    logic [DATA_W-1:0] pat_data;

    // A presented write that the sink has not yet taken must stay on the bus unchanged.
`ifdef FB_INIT_SEQ_BACKPRESSURE_EN
    assign pending = wr_en_q & ~wr_ready;
`else
    assign pending = 1'b0;
`endif

    fb_pattern_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .H_RES  (H_RES)
    ) u_pattern (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (load),
        .advance_i (issue),
        .mode_i    (mode),
        .color0_i  (color0),
        .color1_i  (color1),
        .shift_i   (shift),
        .data_o    (pat_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        wr_en_d    = pending;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        fb_rst_n_d = fb_rst_n_q;
        load       = 1'b0;
        issue      = 1'b0;
        case (state_q)
            ST_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d    = ST_WAIT_RDY;
                    cnt_d      = '0;
                    fb_rst_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_RDY: begin
                if (fb_ready) begin
                    state_d = ST_FILL;
                    load    = 1'b1;
                    n_d     = '0;
                end
            end
            ST_FILL: begin
                if (fb_ready && !pending) begin
                    issue     = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = n_q;
                    wr_data_d = pat_data;
                    n_d       = n_q + 1'b1;
                    if (n_q == LAST_ADDR) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_SETTLE: begin
                // Settle time is measured from acceptance of the final write.
                if (!pending) begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_FILL;
                    load    = 1'b1;
                    n_d     = '0;
                end
            end
            default: state_d = ST_HOLDOFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_HOLDOFF;
            cnt_q      <= '0;
            n_q        <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            fb_rst_n_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            fb_rst_n_q <= fb_rst_n_d;
            busy_q     <= (state_d != ST_DONE);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign fb_rst_n = fb_rst_n_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_fb_init_sequencer.sv
// Directed bench for fb_init_sequencer with a small geometry (16 words, 4 pixels per line).
module tb_fb_init_sequencer;

    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 4;
    localparam int DEPTH   = 16;
    localparam int H_RES   = 4;
    localparam int HOLDOFF = 8;
    localparam int SETTLE  = 32;

    logic              clk = 1'b0;
    logic              reset_n, start, fb_ready;
    logic [1:0]        mode;
    logic [DATA_W-1:0] color0, color1;
    logic [2:0]        shift;
`ifdef FB_INIT_SEQ_BACKPRESSURE_EN
    logic              wr_ready;
`endif
    logic              fb_rst_n, wr_en, busy, done;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int cap_addr[$];
    int cap_data[$];
    int cap_cyc[$];
    int hold_err;
    bit rst_dropped;

    always #5 clk = ~clk;

    fb_init_sequencer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .H_RES   (H_RES),
        .HOLDOFF (HOLDOFF),
        .SETTLE  (SETTLE)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .mode     (mode),
        .color0   (color0),
        .color1   (color1),
        .shift    (shift),
        .fb_ready (fb_ready),
`ifdef FB_INIT_SEQ_BACKPRESSURE_EN
        .wr_ready (wr_ready),
`endif
        .fb_rst_n (fb_rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int expect_pix(int m, int c0, int c1, int sh, int n);
        int col = n % H_RES;
        int row = n / H_RES;
        case (m)
            0:       return c0;
            1:       return ((col >> sh) & 1) != 0 ? c1 : c0;
            2:       return (((col >> sh) ^ (row >> sh)) & 1) != 0 ? c1 : c0;
            default: return n % (1 << DATA_W);
        endcase
    endfunction

    // Records accepted writes until address DEPTH-1 is accepted; optional fb_ready / wr_ready stalls.
    task automatic collect(input int fb_at, input int fb_len, input int wr_at, input int wr_len);
        int fb_left = 0;
        int budget  = 300;
        bit fin     = 0;
        bit fb_trig = 0;
        bit accept;
`ifdef FB_INIT_SEQ_BACKPRESSURE_EN
        int wr_left = 0;
        bit wr_trig = 0;
        logic [DATA_W-1:0] held = '0;
`endif
        cap_addr.delete();
        cap_data.delete();
        cap_cyc.delete();
        hold_err    = 0;
        rst_dropped = 0;
        while (!fin && budget > 0) begin
            step();
            budget--;
            if (fb_rst_n !== 1'b1) rst_dropped = 1;
            if (fb_left > 0) begin
                fb_left--;
                if (fb_left == 0) fb_ready = 1'b1;
            end
            accept = 1'b1;
`ifdef FB_INIT_SEQ_BACKPRESSURE_EN
            if (wr_left > 0) begin
                if (wr_en !== 1'b1 || int'(wr_addr) != wr_at || wr_data !== held) hold_err++;
                wr_left--;
                if (wr_left == 0) wr_ready = 1'b1;
            end
            if (wr_en === 1'b1 && !wr_trig && int'(wr_addr) == wr_at) begin
                wr_trig  = 1;
                wr_left  = wr_len;
                held     = wr_data;
                wr_ready = 1'b0;
            end
            accept = wr_ready;
`else
            if (wr_at >= 0 && wr_len > 0) hold_err = hold_err;
`endif
            if (wr_en === 1'b1 && accept) begin
                cap_addr.push_back(int'(wr_addr));
                cap_data.push_back(int'(wr_data));
                cap_cyc.push_back(cyc);
                if (int'(wr_addr) == DEPTH - 1) fin = 1;
            end
            if (wr_en === 1'b1 && !fb_trig && int'(wr_addr) == fb_at) begin
                fb_trig  = 1;
                fb_left  = fb_len;
                fb_ready = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input int start_hold, output int n, output bit saw_wr);
        n      = 0;
        saw_wr = 0;
        while (done !== 1'b1 && n < 200) begin
            step();
            n++;
            if (wr_en === 1'b1) saw_wr = 1;
            if (n == start_hold) start = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        int k = 0;
        reset_n = 1'b0; start = 1'b0; fb_ready = 1'b1;
        mode = 2'd0; color0 = 4'd2; color1 = 4'd9; shift = 3'd0;
`ifdef FB_INIT_SEQ_BACKPRESSURE_EN
        wr_ready = 1'b1;
`endif
        step();
        step();
        tests_run++;
        if ({fb_rst_n, wr_en, busy, done} !== 4'b0010 || wr_addr !== '0 || wr_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: fb_rst_n,wr_en,busy,done=%b%b%b%b addr=%0d data=%0d, expected 0010 addr=0 data=0",
                     fb_rst_n, wr_en, busy, done, wr_addr, wr_data);
        end
        reset_n = 1'b1;
        while (fb_rst_n !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        tests_run++;
        if (k != HOLDOFF) begin
            tests_failed++;
            $display("FAIL holdoff_release: fb_rst_n rose after %0d cycles, expected %0d", k, HOLDOFF);
        end
    endtask

    task automatic test_solid();
        int n;
        bit saw;
        collect(-1, 0, -1, 0);
        tests_run++;
        if (cap_addr.size() != DEPTH) begin
            tests_failed++;
            $display("FAIL solid_count: got %0d writes, expected %0d", cap_addr.size(), DEPTH);
        end
        for (int i = 0; i < cap_addr.size(); i++) begin
            tests_run++;
            if (cap_addr[i] != i || cap_data[i] != 2) begin
                tests_failed++;
                $display("FAIL solid_write[%0d]: addr=%0d data=%0d, expected addr=%0d data=2", i, cap_addr[i], cap_data[i], i);
            end
        end
        wait_done(0, n, saw);
        tests_run++;
        if (n != SETTLE || saw || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL solid_settle: done after %0d cyc wr_en_seen=%0d busy=%b, expected %0d cyc 0 0", n, saw, busy, SETTLE);
        end
    endtask

    task automatic test_checker();
        int exp_chk[16] = '{1, 2, 1, 2, 2, 1, 2, 1, 1, 2, 1, 2, 2, 1, 2, 1};
        int n;
        bit saw;
        mode = 2'd2; shift = 3'd0; color0 = 4'd1; color1 = 4'd2;
        pulse_start();
        collect(-1, 0, -1, 0);
        tests_run++;
        if (cap_addr.size() != DEPTH) begin
            tests_failed++;
            $display("FAIL checker_count: got %0d writes, expected %0d", cap_addr.size(), DEPTH);
        end
        for (int i = 0; i < cap_addr.size(); i++) begin
            tests_run++;
            if (cap_addr[i] != i || cap_data[i] != exp_chk[i]) begin
                tests_failed++;
                $display("FAIL checker_write[%0d]: addr=%0d data=%0d, expected addr=%0d data=%0d", i, cap_addr[i], cap_data[i], i, exp_chk[i]);
            end
        end
        wait_done(0, n, saw);
    endtask

    task automatic test_fb_stall();
        int n;
        bit saw;
        mode = 2'd1; shift = 3'd1; color0 = 4'd5; color1 = 4'd10;
        pulse_start();
        collect(6, 5, -1, 0);
        tests_run++;
        if (cap_addr.size() != DEPTH) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d writes, expected %0d", cap_addr.size(), DEPTH);
        end
        for (int i = 0; i < cap_addr.size(); i++) begin
            tests_run++;
            if (cap_addr[i] != i || cap_data[i] != expect_pix(1, 5, 10, 1, i)) begin
                tests_failed++;
                $display("FAIL stall_write[%0d]: addr=%0d data=%0d, expected addr=%0d data=%0d", i, cap_addr[i], cap_data[i], i, expect_pix(1, 5, 10, 1, i));
            end
        end
        tests_run++;
        if (cap_cyc[7] - cap_cyc[6] != 6) begin
            tests_failed++;
            $display("FAIL stall_gap: addr 6->7 took %0d cycles, expected 6", cap_cyc[7] - cap_cyc[6]);
        end
        wait_done(0, n, saw);
        tests_run++;
        if (n != SETTLE) begin
            tests_failed++;
            $display("FAIL stall_settle: done after %0d cyc, expected %0d", n, SETTLE);
        end
    endtask

    task automatic test_restart_ramp();
        int n;
        bit saw;
        mode = 2'd3;
        pulse_start();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b1 || fb_rst_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_flags: done=%b busy=%b fb_rst_n=%b, expected 0 1 1", done, busy, fb_rst_n);
        end
        collect(-1, 0, -1, 0);
        tests_run++;
        if (cap_addr.size() != DEPTH || rst_dropped) begin
            tests_failed++;
            $display("FAIL ramp_count: got %0d writes fb_rst_n_dropped=%0d, expected %0d 0", cap_addr.size(), rst_dropped, DEPTH);
        end
        for (int i = 0; i < cap_addr.size(); i++) begin
            tests_run++;
            if (cap_addr[i] != i || cap_data[i] != i) begin
                tests_failed++;
                $display("FAIL ramp_write[%0d]: addr=%0d data=%0d, expected %0d %0d", i, cap_addr[i], cap_data[i], i, i);
            end
        end
        wait_done(0, n, saw);
        tests_run++;
        if (n != SETTLE) begin
            tests_failed++;
            $display("FAIL ramp_settle: done after %0d cyc, expected %0d", n, SETTLE);
        end
    endtask

    task automatic test_start_ignored();
        int n;
        bit saw;
        bit bad = 0;
        mode = 2'd0; color0 = 4'd7;
        pulse_start();
        start = 1'b1;
        collect(-1, 0, -1, 0);
        tests_run++;
        if (cap_addr.size() != DEPTH) begin
            tests_failed++;
            $display("FAIL ignore_count: got %0d writes, expected %0d", cap_addr.size(), DEPTH);
        end
        for (int i = 0; i < cap_addr.size(); i++) begin
            tests_run++;
            if (cap_addr[i] != i || cap_data[i] != 7) begin
                tests_failed++;
                $display("FAIL ignore_write[%0d]: addr=%0d data=%0d, expected addr=%0d data=7", i, cap_addr[i], cap_data[i], i);
            end
        end
        wait_done(20, n, saw);
        tests_run++;
        if (n != SETTLE || saw) begin
            tests_failed++;
            $display("FAIL ignore_settle: done after %0d cyc wr_en_seen=%0d, expected %0d 0", n, saw, SETTLE);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (done !== 1'b1 || wr_en !== 1'b0) bad = 1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL ignore_done_stable: done/wr_en changed after done, expected done=1 wr_en=0");
        end
    endtask

`ifdef FB_INIT_SEQ_BACKPRESSURE_EN
    task automatic test_backpressure();
        int n;
        bit saw;
        mode = 2'd3;
        pulse_start();
        collect(-1, 0, 3, 4);
        tests_run++;
        if (hold_err != 0 || cap_addr.size() != DEPTH) begin
            tests_failed++;
            $display("FAIL bp_hold: hold errors=%0d writes=%0d, expected 0 %0d", hold_err, cap_addr.size(), DEPTH);
        end
        for (int i = 0; i < cap_addr.size(); i++) begin
            tests_run++;
            if (cap_addr[i] != i || cap_data[i] != i) begin
                tests_failed++;
                $display("FAIL bp_write[%0d]: addr=%0d data=%0d, expected %0d %0d", i, cap_addr[i], cap_data[i], i, i);
            end
        end
        wait_done(0, n, saw);
        tests_run++;
        if (n != SETTLE) begin
            tests_failed++;
            $display("FAIL bp_settle: done after %0d cyc, expected %0d", n, SETTLE);
        end
    endtask
`endif

    task automatic test_reset_midfill();
        int k = 0;
        int n;
        bit saw;
        mode = 2'd0; color0 = 4'd2;
        pulse_start();
        while (!(wr_en === 1'b1 && int'(wr_addr) == 9) && k < 50) begin
            step();
            k++;
        end
        tests_run++;
        if (k >= 50) begin
            tests_failed++;
            $display("FAIL midfill_reach: addr 9 not written within %0d cycles, expected it", k);
        end
        reset_n = 1'b0;
        step();
        tests_run++;
        if (wr_en !== 1'b0 || fb_rst_n !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midfill_abort: wr_en=%b fb_rst_n=%b busy=%b done=%b, expected 0 0 1 0", wr_en, fb_rst_n, busy, done);
        end
        reset_n = 1'b1;
        color0  = 4'd3;
        k = 0;
        while (fb_rst_n !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        tests_run++;
        if (k != HOLDOFF) begin
            tests_failed++;
            $display("FAIL midfill_holdoff: fb_rst_n rose after %0d cycles, expected %0d", k, HOLDOFF);
        end
        collect(-1, 0, -1, 0);
        tests_run++;
        if (cap_addr.size() != DEPTH) begin
            tests_failed++;
            $display("FAIL midfill_count: got %0d writes, expected %0d", cap_addr.size(), DEPTH);
        end
        for (int i = 0; i < cap_addr.size(); i++) begin
            tests_run++;
            if (cap_addr[i] != i || cap_data[i] != 3) begin
                tests_failed++;
                $display("FAIL midfill_write[%0d]: addr=%0d data=%0d, expected addr=%0d data=3", i, cap_addr[i], cap_data[i], i);
            end
        end
        wait_done(0, n, saw);
        tests_run++;
        if (n != SETTLE || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL midfill_settle: done after %0d cyc, expected %0d", n, SETTLE);
        end
    endtask

    initial begin
        test_reset();
        test_solid();
        test_checker();
        test_fb_stall();
        test_restart_ramp();
        test_start_ignored();
`ifdef FB_INIT_SEQ_BACKPRESSURE_EN
        test_backpressure();
`endif
        test_reset_midfill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
